// File: rtl/lif_layer_if.sv
// Spike/state bus of a leaky integrate-and-fire layer.
// Carries the per-step synaptic currents into the layer and the spike
// pulses back out, so layers can be chained or fed from input pins.
//
// Handshake: step is a one-cycle strobe with no back-pressure. The layer is
// always ready, so every cycle with step=1 is consumed at that rising edge
// together with isyn. spike and spike_any are registered and valid for
// exactly one clk cycle after the edge that produced them.
interface lif_layer_if #(
    parameter int N_NEURONS = 4,
    parameter int IN_W      = 8
);
    logic                      step;
    logic [N_NEURONS*IN_W-1:0] isyn;
    logic [N_NEURONS-1:0]      spike;
    logic                      spike_any;

    // Producer side: drives the strobe and currents, receives spikes
    modport master (
        output step,
        output isyn,
        input  spike,
        input  spike_any
    );

    // Layer side
    modport slave (
        input  step,
        input  isyn,
        output spike,
        output spike_any
    );
endinterface

// File: rtl/lif_layer.sv
// Parallel array of leaky integrate-and-fire neurons.
// All neurons share one runtime-programmable threshold, leak shift and
// refractory period. Membrane arithmetic saturates at the top of the
// potential range. A saturating counter totals the spikes that have
// appeared on the output register, and any neuron's potential can be
// read back combinationally for debug.
module lif_layer #(
    parameter int N_NEURONS  = 4,
    parameter int IN_W       = 8,
    parameter int POT_W      = 12,
    parameter int REFRAC_W   = 4,
    parameter int THRESH_RST = 200,
    parameter int LEAK_RST   = 4,
    parameter int REFRAC_RST = 2,
    localparam int SEL_W     = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    lif_layer_if.slave          bus,
    input  logic                cfg_we,
    input  logic [POT_W-1:0]    cfg_thresh,
    input  logic [2:0]          cfg_leak,
    input  logic [REFRAC_W-1:0] cfg_refrac,
    input  logic                cnt_clr,
    output logic [15:0]         spike_cnt,
    input  logic [SEL_W-1:0]    pot_sel,
    output logic [POT_W-1:0]    pot_out
);

    // Wide enough to hold a popcount of up to 16 simultaneous spikes
    localparam int POP_W = 5;

    // Shared configuration
    logic [POT_W-1:0]    thresh_q;
    logic [2:0]          leak_q;
    logic [REFRAC_W-1:0] refrac_q;

    // Per-neuron state
    logic [POT_W-1:0]    v_q   [N_NEURONS];
    logic [REFRAC_W-1:0] rc_q  [N_NEURONS];
    logic [N_NEURONS-1:0] spike_q;

    // Per-neuron candidate update
    logic [POT_W-1:0]    leak_amt [N_NEURONS];
    logic [POT_W:0]      v_sum    [N_NEURONS];
    logic [POT_W-1:0]    v_next   [N_NEURONS];
    logic [N_NEURONS-1:0] fire;

    // Spike counter helpers
    logic [POP_W-1:0]    spike_pop;
    logic [16:0]         cnt_sum;

    // Leak, integrate and clamp for every neuron; V - (V >> k) never goes
    // negative, so only the upper bound needs clamping
    always_comb begin
        for (int i = 0; i < N_NEURONS; i++) begin
            leak_amt[i] = (leak_q == 3'd0) ? '0 : (v_q[i] >> leak_q);
            v_sum[i]    = {1'b0, v_q[i]} - {1'b0, leak_amt[i]}
                        + {{(POT_W + 1 - IN_W){1'b0}}, bus.isyn[i*IN_W +: IN_W]};
            v_next[i]   = v_sum[i][POT_W] ? {POT_W{1'b1}} : v_sum[i][POT_W-1:0];
            fire[i]     = (v_next[i] >= thresh_q);
        end
    end

    // Configuration registers; a step in the same cycle still sees the old values
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            thresh_q <= POT_W'(THRESH_RST);
            leak_q   <= 3'(LEAK_RST);
            refrac_q <= REFRAC_W'(REFRAC_RST);
        end else if (cfg_we) begin
            thresh_q <= cfg_thresh;
            leak_q   <= cfg_leak;
            refrac_q <= cfg_refrac;
        end
    end

    // Neuron update on step; spikes are single-cycle pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_NEURONS; i++) begin
                v_q[i]  <= '0;
                rc_q[i] <= '0;
            end
            spike_q <= '0;
        end else if (bus.step) begin
            for (int i = 0; i < N_NEURONS; i++) begin
                if (rc_q[i] != '0) begin
                    // Refractory: count down, ignore input, stay at rest
                    rc_q[i]    <= rc_q[i] - 1'b1;
                    v_q[i]     <= '0;
                    spike_q[i] <= 1'b0;
                end else if (fire[i]) begin
                    v_q[i]     <= '0;
                    rc_q[i]    <= refrac_q;
                    spike_q[i] <= 1'b1;
                end else begin
                    v_q[i]     <= v_next[i];
                    spike_q[i] <= 1'b0;
                end
            end
        end else begin
            spike_q <= '0;
        end
    end

    // Number of spikes currently presented on the output register
    always_comb begin
        spike_pop = '0;
        for (int i = 0; i < N_NEURONS; i++) begin
            spike_pop = spike_pop + POP_W'(spike_q[i]);
        end
        cnt_sum = {1'b0, spike_cnt} + 17'(spike_pop);
    end

    // Saturating spike counter; clear wins over increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            spike_cnt <= '0;
        end else if (cnt_clr) begin
            spike_cnt <= '0;
        end else if (cnt_sum[16]) begin
            spike_cnt <= 16'hFFFF;
        end else begin
            spike_cnt <= cnt_sum[15:0];
        end
    end

    // Debug readback; unused selector codes read as zero
    always_comb begin
        pot_out = '0;
        for (int i = 0; i < N_NEURONS; i++) begin
            if (pot_sel == SEL_W'(i)) begin
                pot_out = v_q[i];
            end
        end
    end

    assign bus.spike     = spike_q;
    assign bus.spike_any = |spike_q;

endmodule

// File: tb/tb_lif_layer.sv
// Directed bench for lif_layer: reset, integration, refractory, leak,
// saturation, configuration timing, spike counter, step gating and readback.
module tb_lif_layer;

    // ---------------- clock / reset / signals ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        cfg_we;
    logic [11:0] cfg_thresh;
    logic [2:0]  cfg_leak;
    logic [3:0]  cfg_refrac;
    logic        cnt_clr;
    logic [1:0]  pot_sel4;
    logic [2:0]  pot_sel5;
    logic [15:0] cnt4, cnt5;
    logic [11:0] pot4, pot5;

    int checks   = 0;
    int failures = 0;

    lif_layer_if #(.N_NEURONS(4), .IN_W(8)) bus4 ();
    lif_layer_if #(.N_NEURONS(5), .IN_W(8)) bus5 ();

    lif_layer #(.N_NEURONS(4)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus4),
        .cfg_we    (cfg_we),
        .cfg_thresh(cfg_thresh),
        .cfg_leak  (cfg_leak),
        .cfg_refrac(cfg_refrac),
        .cnt_clr   (cnt_clr),
        .spike_cnt (cnt4),
        .pot_sel   (pot_sel4),
        .pot_out   (pot4)
    );

    // Second instance with a 3-bit selector so out-of-range codes exist
    lif_layer #(.N_NEURONS(5)) u_dut5 (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus5),
        .cfg_we    (cfg_we),
        .cfg_thresh(cfg_thresh),
        .cfg_leak  (cfg_leak),
        .cfg_refrac(cfg_refrac),
        .cnt_clr   (cnt_clr),
        .spike_cnt (cnt5),
        .pot_sel   (pot_sel5),
        .pot_out   (pot5)
    );

    // ---------------- driver / checker tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic pot_chk(input string tag, input int idx, input int exp);
        pot_sel4 = 2'(idx);
        #1;
        chk(tag, 32'(pot4), 32'(exp));
    endtask

    task automatic do_reset();
        bus4.step = 1'b0;
        bus5.step = 1'b0;
        cnt_clr   = 1'b0;
        cfg_we    = 1'b0;
        rst_n     = 1'b0;
        #1;
        rst_n     = 1'b1;
    endtask

    task automatic cfg(input logic [11:0] th, input logic [2:0] lk, input logic [3:0] rf);
        bus4.step  = 1'b0;
        cfg_we     = 1'b1;
        cfg_thresh = th;
        cfg_leak   = lk;
        cfg_refrac = rf;
        tick();
        cfg_we     = 1'b0;
    endtask

    int leak_exp [7] = '{100, 150, 175, 188, 194, 197, 199};

    // ---------------- directed sequence ----------------
    initial begin
        rst_n = 1'b0; cfg_we = 1'b0; cfg_thresh = '0; cfg_leak = '0; cfg_refrac = '0;
        cnt_clr = 1'b0; pot_sel4 = '0; pot_sel5 = '0;
        bus4.step = 1'b0; bus4.isyn = '0;
        bus5.step = 1'b0; bus5.isyn = '0;
        #12 rst_n = 1'b1;
        tick();

        // Reset state
        chk("rst_spike", 32'(bus4.spike), 0);
        chk("rst_any", 32'(bus4.spike_any), 0);
        chk("rst_cnt", 32'(cnt4), 0);
        for (int i = 0; i < 4; i++) pot_chk("rst_pot", i, 0);

        // Reset configuration: thresh 200, leak 4, refrac 2
        bus4.isyn = {24'd0, 8'd100};
        bus4.step = 1'b1;
        tick(); pot_chk("def_v1", 0, 100);
        tick(); pot_chk("def_v2", 0, 194);
        tick(); chk("def_spike", 32'(bus4.spike), 1); pot_chk("def_v3", 0, 0);
        tick(); chk("def_refr_spike", 32'(bus4.spike), 0);
        chk("def_cnt", 32'(cnt4), 1);
        // Asynchronous reset mid-refractory, between edges
        rst_n = 1'b0;
        #1;
        chk("midrst_cnt", 32'(cnt4), 0);
        pot_chk("midrst_pot", 0, 0);
        rst_n = 1'b1;
        tick(); pot_chk("midrst_rc_clear", 0, 100);

        // Integration and refractory
        do_reset();
        cfg(12'd200, 3'd0, 4'd2);
        bus4.isyn = {24'd0, 8'd50};
        bus4.step = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            tick(); pot_chk("int_v", 0, 50 * k);
            chk("int_nospike", 32'(bus4.spike), 0);
        end
        tick(); chk("int_spike", 32'(bus4.spike), 1); chk("int_any", 32'(bus4.spike_any), 1);
        pot_chk("int_v_zero", 0, 0);
        tick(); chk("int_pulse_width", 32'(bus4.spike), 0); pot_chk("int_refr5", 0, 0);
        chk("int_cnt", 32'(cnt4), 1);
        tick(); pot_chk("int_refr6", 0, 0);
        tick(); pot_chk("int_resume", 0, 50); chk("int_cnt_once", 32'(cnt4), 1);

        // Leak shift 1
        do_reset();
        cfg(12'd200, 3'd1, 4'd2);
        bus4.isyn = {24'd0, 8'd100};
        bus4.step = 1'b1;
        for (int k = 0; k < 7; k++) begin
            tick(); pot_chk("leak_v", 0, leak_exp[k]);
        end
        tick(); chk("leak_spike", 32'(bus4.spike), 1);

        // Saturation
        do_reset();
        cfg(12'd4095, 3'd0, 4'd2);
        bus4.isyn = {24'd0, 8'd255};
        bus4.step = 1'b1;
        repeat (16) tick();
        pot_chk("sat_v16", 0, 4080);
        chk("sat_nospike", 32'(bus4.spike), 0);
        tick(); chk("sat_spike", 32'(bus4.spike), 1); pot_chk("sat_v17", 0, 0);

        // Config write in the same cycle as a step
        do_reset();
        cfg(12'd200, 3'd0, 4'd2);
        bus4.isyn  = {24'd0, 8'd60};
        cfg_we     = 1'b1;
        cfg_thresh = 12'd50;
        cfg_leak   = 3'd0;
        cfg_refrac = 4'd2;
        bus4.step  = 1'b1;
        tick();
        cfg_we = 1'b0;
        chk("cfgt_old_thresh", 32'(bus4.spike), 0); pot_chk("cfgt_v", 0, 60);
        tick(); chk("cfgt_new_thresh", 32'(bus4.spike), 1); pot_chk("cfgt_v0", 0, 0);

        // Counter: threshold 0, refractory 0, all neurons fire every step
        do_reset();
        cfg(12'd0, 3'd0, 4'd0);
        bus4.isyn = '0;
        bus4.step = 1'b1;
        repeat (3) tick();
        chk("cnt_all_spike", 32'(bus4.spike), 32'hF);
        chk("cnt_by4", 32'(cnt4), 8);
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        chk("cnt_clr", 32'(cnt4), 0);
        chk("cnt_clr_spike", 32'(bus4.spike), 32'hF);
        repeat (16383) tick();
        chk("cnt_pre_sat", 32'(cnt4), 65532);
        tick(); chk("cnt_sat", 32'(cnt4), 65535);
        tick(); chk("cnt_hold", 32'(cnt4), 65535);
        // Reset while spikes are high
        rst_n = 1'b0;
        #1;
        chk("rst_spike_hi", 32'(bus4.spike), 0);
        chk("rst_cnt_sat", 32'(cnt4), 0);
        rst_n = 1'b1;

        // Step gating
        do_reset();
        cfg(12'd1000, 3'd0, 4'd2);
        bus4.isyn = {8'd40, 8'd30, 8'd20, 8'd10};
        bus4.step = 1'b1;
        tick();
        bus4.step = 1'b0;
        for (int k = 0; k < 10; k++) begin
            bus4.isyn = 32'($urandom_range(32'hFFFF_FFFF, 0));
            tick();
            chk("gate_spike", 32'(bus4.spike), 0);
        end
        for (int i = 0; i < 4; i++) pot_chk("gate_v", i, 10 * (i + 1));
        chk("gate_cnt", 32'(cnt4), 0);

        // Readback range on the five-neuron instance
        do_reset();
        bus5.isyn = {8'd77, 32'd0};
        bus5.step = 1'b1;
        tick();
        bus5.step = 1'b0;
        pot_sel5 = 3'd4; #1; chk("rb_in_range", 32'(pot5), 77);
        pot_sel5 = 3'd5; #1; chk("rb_sel5", 32'(pot5), 0);
        pot_sel5 = 3'd7; #1; chk("rb_sel7", 32'(pot5), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
